// File: rtl/ras_ctrl_if.sv
// Decode/execute-side bundle for the return-address stack.
// The pipeline drives the master side, and ras_ctrl sits on the slave side.
interface ras_ctrl_if #(
    parameter int AW    = 16,
    parameter int PTR_W = 3
);
    logic           dec_valid;
    logic           jr_en;
    logic           reg_7_en;
    logic [AW-1:0]  pc_inc;
    logic           res_valid;
    logic [AW-1:0]  res_target;
    logic           flush;
    logic           pred_valid;
    logic [AW-1:0]  pred_target;
    logic           stall;
    logic           mispredict;
    logic [AW-1:0]  redirect_pc;
    logic [PTR_W:0] ras_count;

    modport master (
        output dec_valid, jr_en, reg_7_en, pc_inc, res_valid, res_target, flush,
        input  pred_valid, pred_target, stall, mispredict, redirect_pc, ras_count
    );

    modport slave (
        input  dec_valid, jr_en, reg_7_en, pc_inc, res_valid, res_target, flush,
        output pred_valid, pred_target, stall, mispredict, redirect_pc, ras_count
    );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address stack with a single outstanding register-jump check.
// JAL/JALR push PC+2, and JR/JALR pop a prediction that is later verified against execute.
module ras_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int AW    = 16
) (
    input  logic     clk,
    input  logic     rst,
    ras_ctrl_if.slave bus
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [AW-1:0]    pend_q, pend_d;
    logic [AW-1:0]    pred_target_q, pred_target_d;
    logic [AW-1:0]    redirect_q, redirect_d;
    logic             pred_valid_q, pred_valid_d;
    logic             mis_q, mis_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic             accept, do_pop, do_push, resolve;

    // A new register jump waits until the outstanding one resolves, unless it resolves this cycle.
    assign bus.stall = bus.dec_valid & bus.jr_en & (state_q == PEND) & ~bus.res_valid & ~bus.flush;
    assign accept    = bus.dec_valid & ~bus.stall & ~bus.flush;
    assign do_pop    = accept & bus.jr_en & (count_q != '0);
    assign do_push   = accept & bus.reg_7_en;
    assign resolve   = (state_q == PEND) & bus.res_valid & ~bus.flush;

    always_comb begin
        state_d       = state_q;
        top_d         = top_q;
        count_d       = count_q;
        pend_d        = pend_q;
        pred_target_d = pred_target_q;
        redirect_d    = redirect_q;
        pred_valid_d  = 1'b0;
        mis_d         = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = top_q + 1'b1;

        if (bus.flush) begin
            count_d = '0;
            state_d = IDLE;
        end else begin
            if (resolve) begin
                state_d = IDLE;
                if (bus.res_target != pend_q) begin
                    mis_d      = 1'b1;
                    redirect_d = bus.res_target;
                end
            end
            if (do_pop) begin
                state_d       = PEND;
                pend_d        = mem[top_q];
                pred_valid_d  = 1'b1;
                pred_target_d = mem[top_q];
            end
            // JALR on a nonempty stack replaces the popped slot in place
            if (do_pop && do_push) begin
                wr_en   = 1'b1;
                wr_addr = top_q;
            end else if (do_pop) begin
                top_d   = top_q - 1'b1;
                count_d = count_q - 1'b1;
            end else if (do_push) begin
                wr_en   = 1'b1;
                wr_addr = top_q + 1'b1;
                top_d   = top_q + 1'b1;
                if (count_q != FULL) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            top_q         <= '0;
            count_q       <= '0;
            pend_q        <= '0;
            pred_target_q <= '0;
            redirect_q    <= '0;
            pred_valid_q  <= 1'b0;
            mis_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            top_q         <= top_d;
            count_q       <= count_d;
            pend_q        <= pend_d;
            pred_target_q <= pred_target_d;
            redirect_q    <= redirect_d;
            pred_valid_q  <= pred_valid_d;
            mis_q         <= mis_d;
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_target = pred_target_q;
    assign bus.mispredict  = mis_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.ras_count   = count_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed plus random bench for ras_ctrl, checked against a queue-based stack model.
module tb_ras_ctrl;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int AW    = 16;

    logic clk;
    logic rst;

    ras_ctrl_if #(.AW(AW), .PTR_W(PTR_W)) bus ();

    ras_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the live stack holds at most DEPTH entries, and the oldest entry falls off the front.
    logic [AW-1:0] stk[$];
    logic          m_pend;
    logic [AW-1:0] m_pend_t;
    logic          exp_pv;
    logic [AW-1:0] exp_pt;
    logic          exp_mis;
    logic [AW-1:0] exp_redir;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        stk.delete();
        m_pend = 1'b0;
        m_pend_t = '0;
        exp_pv = 1'b0;
        exp_pt = '0;
        exp_mis = 1'b0;
        exp_redir = '0;
    endtask

    task automatic applyStimulus(input logic dv, input logic jr, input logic r7, input logic [AW-1:0] pc,
                                 input logic rv, input logic [AW-1:0] rt, input logic fl);
        logic          exp_stall;
        logic          acc;
        logic [AW-1:0] t;
        @(negedge clk);
        bus.dec_valid  = dv;
        bus.jr_en      = jr;
        bus.reg_7_en   = r7;
        bus.pc_inc     = pc;
        bus.res_valid  = rv;
        bus.res_target = rt;
        bus.flush      = fl;
        #1;
        exp_stall = dv & jr & m_pend & ~rv & ~fl;
        checkOutput("stall", 32'(bus.stall), 32'(exp_stall));
        @(posedge clk);
        if (fl) begin
            stk.delete();
            m_pend  = 1'b0;
            exp_pv  = 1'b0;
            exp_mis = 1'b0;
        end else begin
            exp_pv  = 1'b0;
            exp_mis = 1'b0;
            if (m_pend && rv) begin
                if (rt != m_pend_t) begin
                    exp_mis   = 1'b1;
                    exp_redir = rt;
                end
                m_pend = 1'b0;
            end
            acc = dv & ~exp_stall;
            if (acc && jr && stk.size() > 0) begin
                t        = stk.pop_back();
                exp_pv   = 1'b1;
                exp_pt   = t;
                m_pend   = 1'b1;
                m_pend_t = t;
            end
            if (acc && r7) begin
                stk.push_back(pc);
                if (stk.size() > DEPTH) void'(stk.pop_front());
            end
        end
        #1;
        checkOutput("pred_valid", 32'(bus.pred_valid), 32'(exp_pv));
        if (exp_pv) checkOutput("pred_target", 32'(bus.pred_target), 32'(exp_pt));
        checkOutput("mispredict", 32'(bus.mispredict), 32'(exp_mis));
        if (exp_mis) checkOutput("redirect_pc", 32'(bus.redirect_pc), 32'(exp_redir));
        checkOutput("ras_count", 32'(bus.ras_count), 32'(stk.size()));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic jal(input logic [AW-1:0] pc);
        applyStimulus(1'b1, 1'b0, 1'b1, pc, 1'b0, '0, 1'b0);
    endtask

    task automatic jr(input logic rv, input logic [AW-1:0] rt);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, rv, rt, 1'b0);
    endtask

    task automatic resolve(input logic [AW-1:0] rt);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, rt, 1'b0);
    endtask

    initial begin
        logic          dv, j, r7, rv, fl;
        logic [AW-1:0] pc, rt;
        $display("[TB] ras_ctrl bench starting");
        modelReset();
        bus.dec_valid = 0; bus.jr_en = 0; bus.reg_7_en = 0; bus.pc_inc = '0;
        bus.res_valid = 0; bus.res_target = '0; bus.flush = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pred_valid", 32'(bus.pred_valid), 32'h0);
        checkOutput("rst_pred_target", 32'(bus.pred_target), 32'h0);
        checkOutput("rst_mispredict", 32'(bus.mispredict), 32'h0);
        checkOutput("rst_redirect_pc", 32'(bus.redirect_pc), 32'h0);
        checkOutput("rst_ras_count", 32'(bus.ras_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single push/pop with a correct resolution
        jal(16'h0010);
        jr(1'b0, '0);
        checkOutput("t1_pred_target", 32'(bus.pred_target), 32'h0010);
        idle();
        resolve(16'h0010);
        checkOutput("t1_count", 32'(bus.ras_count), 32'h0);

        // Wrong resolution yields a one-cycle redirect
        jal(16'h0100);
        jal(16'h0200);
        jr(1'b0, '0);
        checkOutput("t2_pred_target", 32'(bus.pred_target), 32'h0200);
        resolve(16'h0300);
        checkOutput("t2_mispredict", 32'(bus.mispredict), 32'h1);
        checkOutput("t2_redirect", 32'(bus.redirect_pc), 32'h0300);
        idle();
        checkOutput("t2_mis_pulse", 32'(bus.mispredict), 32'h0);
        jr(1'b0, '0);
        checkOutput("t2_second_pred", 32'(bus.pred_target), 32'h0100);
        resolve(16'h0100);

        // Overfill: the oldest entry is lost and the count saturates
        for (int k = 1; k <= 9; k++) jal(16'(2 * k));
        checkOutput("t3_saturate", 32'(bus.ras_count), 32'd8);
        for (int k = 9; k >= 1; k--) begin
            jr(1'b0, '0);
            if (k >= 2) checkOutput("t3_pred", 32'(bus.pred_target), 32'(2 * k));
            else checkOutput("t3_empty_pred", 32'(bus.pred_valid), 32'h0);
            resolve(16'(2 * k));
        end

        // Stall in PEND, then acceptance when resolution coincides with the new jump
        jal(16'h0020);
        jal(16'h0030);
        jr(1'b0, '0);
        jr(1'b0, '0);
        checkOutput("t4_stalled_count", 32'(bus.ras_count), 32'd1);
        jr(1'b1, 16'h0030);
        checkOutput("t4_new_pred", 32'(bus.pred_target), 32'h0020);
        resolve(16'h0020);

        // JALR swaps the top entry in place
        jal(16'h0040);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0080, 1'b0, '0, 1'b0);
        checkOutput("t5_pred", 32'(bus.pred_target), 32'h0040);
        checkOutput("t5_count", 32'(bus.ras_count), 32'd1);
        resolve(16'h0040);
        jr(1'b0, '0);
        checkOutput("t5_next_pred", 32'(bus.pred_target), 32'h0080);
        resolve(16'h0080);

        // Empty-stack JR, flush while in PEND, and JALR on an empty stack
        jr(1'b0, '0);
        jal(16'h0050);
        jal(16'h0060);
        jr(1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0070, 1'b1, 16'h0999, 1'b1);
        idle();
        checkOutput("t6_flush_mis", 32'(bus.mispredict), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h00a0, 1'b0, '0, 1'b0);
        checkOutput("t6_jalr_empty", 32'(bus.ras_count), 32'd1);

        // Asynchronous reset while a check is outstanding
        jal(16'h00b0);
        jr(1'b0, '0);
        #1 rst = 1'b1;
        #1;
        checkOutput("t7_pred_valid", 32'(bus.pred_valid), 32'h0);
        checkOutput("t7_pred_target", 32'(bus.pred_target), 32'h0);
        checkOutput("t7_count", 32'(bus.ras_count), 32'h0);
        checkOutput("t7_mispredict", 32'(bus.mispredict), 32'h0);
        checkOutput("t7_redirect", 32'(bus.redirect_pc), 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            dv = ($urandom_range(0, 3) != 0);
            j  = 1'($urandom_range(0, 1));
            r7 = ($urandom_range(0, 2) != 0);
            pc = 16'($urandom) & 16'hfffe;
            rv = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 1) != 0) ? m_pend_t : (16'($urandom) & 16'hfffe);
            fl = ($urandom_range(0, 24) == 0);
            applyStimulus(dv, j, r7, pc, rv, rt, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
